scratch_pad_loader: RTL and testbench
=====================================

// Module: scratch_pad_loader
// PURPOSE
//  Upstream feeder for the scratch pad. Accepts a 32-bit word stream over a
//  valid/ready handshake and turns it into the scratch-pad write controls
//  (step, bram_num, bram_addr, bram_layer, data_received). Per load command it
//  fills the activation BRAMs first (step=1), then the weight BRAMs (step=2).
//  Sits between the host/DMA receive path and the scratch pad.
// PARAMETERS
//  SYS_WIDTH   64  number of weight BRAMs (1..64, fits bram_num[5:0])
//  SYS_HEIGHT  1   number of activation BRAMs (1..64)
//  BUFFER_SIZE 5   max layers per load (1..5: addr 2*layer+1 must be < 2*BUFFER_SIZE)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active high
//  start          in   1   one-cycle load request, sampled only in IDLE
//  num_layers     in   3   layers to load, sampled with start
//  in_valid       in   1   in_data holds a word
//  in_ready       out  1   loader accepts a word this cycle
//  in_data        in   32  payload word
//  step           out  3   0 = no write, 1 = activation write, 2 = weight write
//  bram_num       out  6   target BRAM index within the phase
//  bram_addr      out  1   word half within the layer slot (0, then 1)
//  bram_layer     out  3   layer slot
//  data_received  out  32  word to write
//  busy           out  1   load in progress
//  done           out  1   one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0: step, bram_num, bram_addr, bram_layer,
//    data_received, in_ready, busy, done. Counters cleared. Reset mid-load
//    aborts the load. The partial load is discarded and no done is emitted.
//  - FSM: IDLE -> LOAD_ACT (on start) -> LOAD_WGT -> DONE -> IDLE.
//  - IDLE: start=1 latches L = min(num_layers, BUFFER_SIZE).
//    If L=0, go directly to DONE with no writes. Otherwise go to LOAD_ACT.
//    start is ignored in every other state.
//  - in_ready = 1 exactly in LOAD_ACT and LOAD_WGT. A word is accepted when
//    in_valid & in_ready. Throughput is 1 word/cycle, with no bubble between
//    the two phases.
//  - Counter order per phase: layer outermost (0..L-1), then bram_num
//    (0..N-1, N = SYS_HEIGHT or SYS_WIDTH), then bram_addr (0,1) innermost.
//    Each phase takes L*N*2 words. Defaults with L=5: 10 activation words,
//    640 weight words.
//  - Outputs are registered, one cycle of latency. A word accepted in cycle t
//    produces step = phase code, plus its counters and data_received, in t+1.
//  - In any cycle after an idle-input cycle, step = 0. The scratch pad's write
//    enable depends only on step and bram_num, so step must never stay at
//    1 or 2 across a non-accept cycle. Otherwise a BRAM is rewritten.
//    bram_num, bram_addr, bram_layer and data_received hold their last values
//    while step = 0.
//  - Phase transitions:
//    - Accepting the last activation word (layer L-1, bram N-1, addr 1)
//      moves the FSM to LOAD_WGT and resets the counters to 0.
//    - Accepting the last weight word moves it to DONE; in_ready drops the
//      next cycle.
//  - DONE lasts 1 cycle: done=1, then IDLE. With t = accept cycle of the final
//    word, the last write is at t+1 and done is at t+2. A start in the done
//    cycle is ignored.
//  - busy = 1 from the cycle after start is accepted through the done cycle
//    inclusive.
//  - Width rules: bram_layer is L-1 max (3 bits). bram_num is N-1 max (6 bits).
//    Counters wrap only at the phase limits, never at their native bit widths.
// TESTING
//  1. Reset mid LOAD_WGT -> next cycle all outputs 0 and IDLE. A new start
//     with L=1 then runs cleanly from layer 0 / bram 0.
//  2. start, num_layers=2, SYS_HEIGHT=1, SYS_WIDTH=4, in_valid held 1 ->
//     4 writes step=1 (n0 a0 l0, n0 a1 l0, n0 a0 l1, n0 a1 l1), then 16 writes
//     step=2, back to back. done occurs 1 cycle after the last write.
//  3. Same load with in_valid toggling 1,0,1,0 -> step=0 in every cycle after
//     an idle input. No duplicate (step, bram_num, addr, layer) tuple appears.
//  4. num_layers=0 -> no step!=0 cycles, in_ready never 1, done 2 cycles
//     after start. num_layers=7 -> clamped: layers 0..4 only.
//  5. start pulsed during busy and in the done cycle -> ignored; write count
//     and sequence unchanged.
//  6. Scoreboard against the scratch pad model with data = word index ->
//     BRAM j, addr 2*l+a holds word l*2N + 2j + a of its phase.

Source files
------------

// File: rtl/scratch_pad_loader.sv
// scratch_pad_loader
// Turns a valid/ready stream of 32-bit words into scratch-pad write controls.
// Each load fills the activation BRAMs first (step=1), then the weight BRAMs
// (step=2), walking layer -> bram_num -> bram_addr with addr innermost.
// All write controls are registered: a word accepted in cycle t is presented
// on step/bram_*/data_received in cycle t+1, and step falls back to 0 in any
// cycle that follows a non-accept cycle so no BRAM is ever written twice.

module scratch_pad_loader #(
   parameter int SYS_WIDTH   = 64,
   parameter int SYS_HEIGHT  = 1,
   parameter int BUFFER_SIZE = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  num_layers,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [2:0]  step,
   output logic [5:0]  bram_num,
   output logic        bram_addr,
   output logic [2:0]  bram_layer,
   output logic [31:0] data_received,
   output logic        busy,
   output logic        done
);

   localparam logic [5:0] ACT_LAST = 6'(SYS_HEIGHT - 1);
   localparam logic [5:0] WGT_LAST = 6'(SYS_WIDTH - 1);
   localparam logic [2:0] MAX_LAYERS = 3'(BUFFER_SIZE);

   typedef enum logic [1:0] {
      IDLE,
      LOAD_ACT,
      LOAD_WGT,
      DONE
   } state_t;

   state_t state, next_state;

   logic [2:0] layers;
   logic [2:0] layer_cnt;
   logic [5:0] num_cnt;
   logic       addr_cnt;
   logic       done_q;

   logic       accept;
   logic       start_ok;
   logic       last_word;
   logic [5:0] num_last;
   logic [2:0] clamped_layers;

   // The done pulse is a registered output, so the state register is already
   // back in IDLE during the done cycle; start_ok masks start in that cycle.
   assign in_ready       = (state == LOAD_ACT) || (state == LOAD_WGT);
   assign accept         = in_valid && in_ready;
   assign start_ok       = (state == IDLE) && start && !done_q;
   assign num_last       = (state == LOAD_ACT) ? ACT_LAST : WGT_LAST;
   assign clamped_layers = (num_layers > MAX_LAYERS) ? MAX_LAYERS : num_layers;
   assign last_word      = accept && addr_cnt && (num_cnt == num_last) &&
                           (layer_cnt == layers - 3'd1);
   assign busy           = (state != IDLE) || done_q;
   assign done           = done_q;

   // State register for the load sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a zero-layer request skips straight to DONE
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               next_state = (clamped_layers == 3'd0) ? DONE : LOAD_ACT;
            end
         end
         LOAD_ACT: begin
            if (last_word) begin
               next_state = LOAD_WGT;
            end
         end
         LOAD_WGT: begin
            if (last_word) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Position counters, registered write controls and the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         layers        <= 3'd0;
         layer_cnt     <= 3'd0;
         num_cnt       <= 6'd0;
         addr_cnt      <= 1'b0;
         step          <= 3'd0;
         bram_num      <= 6'd0;
         bram_addr     <= 1'b0;
         bram_layer    <= 3'd0;
         data_received <= 32'd0;
         done_q        <= 1'b0;
      end else begin
         done_q <= (state == DONE);
         step   <= 3'd0;

         if (start_ok) begin
            layers    <= clamped_layers;
            layer_cnt <= 3'd0;
            num_cnt   <= 6'd0;
            addr_cnt  <= 1'b0;
         end

         if (accept) begin
            step          <= (state == LOAD_ACT) ? 3'd1 : 3'd2;
            bram_num      <= num_cnt;
            bram_addr     <= addr_cnt;
            bram_layer    <= layer_cnt;
            data_received <= in_data;

            if (last_word) begin
               layer_cnt <= 3'd0;
               num_cnt   <= 6'd0;
               addr_cnt  <= 1'b0;
            end else if (!addr_cnt) begin
               addr_cnt <= 1'b1;
            end else begin
               addr_cnt <= 1'b0;
               if (num_cnt == num_last) begin
                  num_cnt   <= 6'd0;
                  layer_cnt <= layer_cnt + 3'd1;
               end else begin
                  num_cnt <= num_cnt + 6'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_scratch_pad_loader.sv
// tb_scratch_pad_loader
// Directed bench for scratch_pad_loader with SYS_HEIGHT=1, SYS_WIDTH=4.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge. Every write seen is logged and compared against the
// expected layer/bram/addr walk and a scratch-pad content model.

module tb_scratch_pad_loader;

   localparam int SW = 4;
   localparam int SH = 1;
   localparam int BS = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  num_layers;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  step;
   logic [5:0]  bram_num;
   logic        bram_addr;
   logic [2:0]  bram_layer;
   logic [31:0] data_received;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] got_tuple[$];
   logic [31:0] got_data[$];
   int          done_at;
   int          last_write_at;
   int          ready_seen;
   logic [31:0] word_idx;
   bit          prev_acc;

   scratch_pad_loader #(
      .SYS_WIDTH   (SW),
      .SYS_HEIGHT  (SH),
      .BUFFER_SIZE (BS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_layers    (num_layers),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .step          (step),
      .bram_num      (bram_num),
      .bram_addr     (bram_addr),
      .bram_layer    (bram_layer),
      .data_received (data_received),
      .busy          (busy),
      .done          (done)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] packTuple(input logic [2:0] s, input logic [5:0] n,
                                             input logic a, input logic [2:0] l);
      return {19'd0, s, n, a, l};
   endfunction

   // Issue one load and log every write until done (or the cycle budget runs out)
   task automatic applyStimulus(input logic [2:0] nl, input bit toggle, input bit poke_start);
      got_tuple.delete();
      got_data.delete();
      word_idx      = 32'd0;
      prev_acc      = 1'b0;
      done_at       = -1;
      last_write_at = -1;
      ready_seen    = 0;
      @(posedge clk); #1;
      start      = 1'b1;
      num_layers = nl;
      in_valid   = 1'b0;
      for (int c = 0; c < 200 && done_at < 0; c++) begin
         @(posedge clk); #1;
         start    = poke_start;
         in_valid = toggle ? (c % 2 == 0) : 1'b1;
         in_data  = word_idx;
         @(negedge clk);
         if (step != 3'd0) begin
            got_tuple.push_back(packTuple(step, bram_num, bram_addr, bram_layer));
            got_data.push_back(data_received);
            last_write_at = c;
         end
         if (!prev_acc) checkOutput("idle_step", {29'd0, step}, 32'd0);
         if (in_ready) ready_seen++;
         if (done) done_at = c;
         prev_acc = in_valid && in_ready;
         if (prev_acc) word_idx++;
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("post_busy", {31'd0, busy}, 32'd0);
      checkOutput("post_step", {29'd0, step}, 32'd0);
   endtask

   // Compare the logged writes with the expected walk and scratch-pad contents
   task automatic checkSequence(input int L);
      logic [31:0] act_mem[SH][2*BS];
      logic [31:0] wgt_mem[SW][2*BS];
      int k;
      int n;
      logic [2:0] s;
      logic [5:0] num;
      logic       a;
      logic [2:0] lay;
      int         slot;
      checkOutput("write_count", got_tuple.size(), L * 2 * (SH + SW));
      k = 0;
      for (int p = 1; p <= 2; p++) begin
         n = (p == 1) ? SH : SW;
         for (int l = 0; l < L; l++)
            for (int j = 0; j < n; j++)
               for (int ad = 0; ad < 2; ad++) begin
                  if (k < got_tuple.size())
                     checkOutput("write_tuple", got_tuple[k],
                                 packTuple(3'(p), 6'(j), 1'(ad), 3'(l)));
                  k++;
               end
      end
      for (int j = 0; j < SH; j++) for (int i = 0; i < 2*BS; i++) act_mem[j][i] = '1;
      for (int j = 0; j < SW; j++) for (int i = 0; i < 2*BS; i++) wgt_mem[j][i] = '1;
      for (int i = 0; i < got_tuple.size(); i++) begin
         lay  = got_tuple[i][2:0];
         a    = got_tuple[i][3];
         num  = got_tuple[i][9:4];
         s    = got_tuple[i][12:10];
         slot = 2 * int'(lay) + int'(a);
         if (slot < 2*BS) begin
            if (s == 3'd1 && num < SH) act_mem[num][slot] = got_data[i];
            if (s == 3'd2 && num < SW) wgt_mem[num][slot] = got_data[i];
         end
      end
      for (int l = 0; l < L; l++)
         for (int ad = 0; ad < 2; ad++) begin
            for (int j = 0; j < SH; j++)
               checkOutput("act_mem", act_mem[j][2*l+ad], 32'(l*2*SH + 2*j + ad));
            for (int j = 0; j < SW; j++)
               checkOutput("wgt_mem", wgt_mem[j][2*l+ad], 32'(L*2*SH + l*2*SW + 2*j + ad));
         end
   endtask

   // Check every output for its reset value
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_step"},   {29'd0, step},       32'd0);
      checkOutput({tag, "_num"},    {26'd0, bram_num},   32'd0);
      checkOutput({tag, "_addr"},   {31'd0, bram_addr},  32'd0);
      checkOutput({tag, "_layer"},  {29'd0, bram_layer}, 32'd0);
      checkOutput({tag, "_data"},   data_received,       32'd0);
      checkOutput({tag, "_ready"},  {31'd0, in_ready},   32'd0);
      checkOutput({tag, "_busy"},   {31'd0, busy},       32'd0);
      checkOutput({tag, "_done"},   {31'd0, done},       32'd0);
   endtask

   // Directed test sequence
   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      num_layers = 3'd0;
      in_valid   = 1'b0;
      in_data    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] continuous load, 2 layers");
      applyStimulus(3'd2, 1'b0, 1'b0);
      checkSequence(2);
      checkOutput("cont_done_cycle", done_at, 21);
      checkOutput("cont_done_gap", done_at - last_write_at, 1);
      checkOutput("cont_ready_cycles", ready_seen, 20);

      $display("[TB] toggling valid, 2 layers");
      applyStimulus(3'd2, 1'b1, 1'b0);
      checkSequence(2);
      checkOutput("tog_done_cycle", done_at, 40);

      $display("[TB] zero layers");
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("zero_writes", got_tuple.size(), 0);
      checkOutput("zero_ready", ready_seen, 0);
      checkOutput("zero_done_cycle", done_at, 1);

      $display("[TB] seven layers clamped");
      applyStimulus(3'd7, 1'b0, 1'b0);
      checkSequence(5);
      checkOutput("clamp_done_cycle", done_at, 51);

      $display("[TB] start held through busy and done");
      applyStimulus(3'd2, 1'b0, 1'b1);
      checkSequence(2);
      checkOutput("poke_done_cycle", done_at, 21);

      $display("[TB] reset during weight phase");
      @(posedge clk); #1;
      start      = 1'b1;
      num_layers = 3'd2;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         start    = 1'b0;
         in_valid = 1'b1;
         in_data  = 32'(c + 100);
      end
      @(negedge clk);
      checkOutput("mid_step_wgt", {29'd0, step}, 32'd2);
      @(posedge clk); #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("midrst");
      applyStimulus(3'd1, 1'b0, 1'b0);
      checkSequence(1);
      checkOutput("after_rst_done_cycle", done_at, 11);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
